// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scoreboard.
// Holds forwarding encodings, the "not used" Tuse value, the slot struct and slot helpers.
package hazard_pkg;

  typedef enum logic [2:0] {
    FWD_GRF = 3'b000,
    FWD_W   = 3'b001,
    FWD_M   = 3'b010,
    FWD_E   = 3'b011
  } fwd_sel_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
  } sb_slot_t;

  // One stage of ageing: Tnew counts down and saturates at zero.
  function automatic sb_slot_t sb_age(sb_slot_t s);
    sb_slot_t r;
    r = s;
    if (r.tnew != 2'd0) r.tnew = r.tnew - 2'd1;
    return r;
  endfunction

  // $0 is never a real dependency.
  function automatic logic sb_hit(logic [4:0] a, sb_slot_t s);
    return (a != 5'd0) && (a == s.a3) && s.we;
  endfunction

endpackage

// File: rtl/d_hazard_scoreboard_md_busy_counter.sv
// MDU busy window counter: loads the mult/div latency on a start pulse,
// then counts down; i_start drives the reload. Ports: i_clk, i_reset, i_start, i_div, o_busy.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] LD_DIV  = CW'(DIV_CYCLES);

  logic [CW-1:0] r_cnt;

  // A start always reloads, so a later MDU op overrides an earlier one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_div ? LD_DIV : LD_MULT;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/d_hazard_scoreboard.sv
// D-stage hazard controller: shadow scoreboard of E/M/W producers driving stall
// and rs/rt forwarding selects, plus MDU busy tracking for HI/LO consumers.
module d_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [1:0] D_rs_Tuse,
  input  logic [1:0] D_rt_Tuse,
  input  logic [4:0] D_A3,
  input  logic       D_RegWrite,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic       E_md_start,
  output logic       md_busy,
  output logic [2:0] rsMUXop,
  output logic [2:0] rtMUXop
);

  sb_slot_t r_e;
  sb_slot_t r_m;
  sb_slot_t r_w;
  logic     r_e_md;
  logic     r_e_div;

  logic     w_reg_stall;
  logic     w_md_stall;
  logic     w_stall;
  logic     w_busy;
  fwd_sel_e w_rs_sel;
  fwd_sel_e w_rt_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e     <= '0;
      r_m     <= '0;
      r_w     <= '0;
      r_e_md  <= 1'b0;
      r_e_div <= 1'b0;
    end else begin
      r_w <= sb_age(r_m);
      r_m <= sb_age(r_e);
      if (w_stall) begin
        r_e     <= '0;
        r_e_md  <= 1'b0;
        r_e_div <= 1'b0;
      end else begin
        r_e.a3   <= D_A3;
        r_e.we   <= D_RegWrite;
        r_e.tnew <= D_Tnew;
        r_e_md   <= D_md_start;
        r_e_div  <= D_md_start & D_md_div;
      end
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_cnt (
    .i_clk  (clk),
    .i_reset(reset),
    .i_start(r_e_md),
    .i_div  (r_e_div),
    .o_busy (w_busy)
  );

  // Only E and M can still be too young; W always has Tnew == 0.
  always_comb begin
    w_reg_stall = 1'b0;
    if (sb_hit(D_A1, r_e) && (r_e.tnew > D_rs_Tuse)) w_reg_stall = 1'b1;
    if (sb_hit(D_A1, r_m) && (r_m.tnew > D_rs_Tuse)) w_reg_stall = 1'b1;
    if (sb_hit(D_A2, r_e) && (r_e.tnew > D_rt_Tuse)) w_reg_stall = 1'b1;
    if (sb_hit(D_A2, r_m) && (r_m.tnew > D_rt_Tuse)) w_reg_stall = 1'b1;
  end

  assign w_md_stall = D_md_use & (r_e_md | w_busy);
  assign w_stall    = w_reg_stall | w_md_stall;

  // Youngest ready producer wins; a not-yet-ready one falls through.
  always_comb begin
    w_rs_sel = FWD_GRF;
    if (sb_hit(D_A1, r_e) && (r_e.tnew == 2'd0)) begin
      w_rs_sel = FWD_E;
    end else if (sb_hit(D_A1, r_m) && (r_m.tnew == 2'd0)) begin
      w_rs_sel = FWD_M;
    end else if (sb_hit(D_A1, r_w) && (r_w.tnew == 2'd0)) begin
      w_rs_sel = FWD_W;
    end
  end

  always_comb begin
    w_rt_sel = FWD_GRF;
    if (sb_hit(D_A2, r_e) && (r_e.tnew == 2'd0)) begin
      w_rt_sel = FWD_E;
    end else if (sb_hit(D_A2, r_m) && (r_m.tnew == 2'd0)) begin
      w_rt_sel = FWD_M;
    end else if (sb_hit(D_A2, r_w) && (r_w.tnew == 2'd0)) begin
      w_rt_sel = FWD_W;
    end
  end

  assign stall      = w_stall;
  assign E_md_start = r_e_md;
  assign md_busy    = w_busy;
  assign rsMUXop    = w_rs_sel;
  assign rtMUXop    = w_rt_sel;

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Directed bench for d_hazard_scoreboard with an expected-result queue.
// Each step drives D, queues the expected outputs, then pops and checks them.
module tb_d_hazard_scoreboard;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [1:0] rsT;
    logic [1:0] rtT;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tn;
    logic       ms;
    logic       md;
    logic       mu;
  } din_t;

  typedef struct packed {
    logic       st;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       mds;
    logic       bz;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] D_A1 = '0;
  logic [4:0] D_A2 = '0;
  logic [1:0] D_rs_Tuse = 2'd3;
  logic [1:0] D_rt_Tuse = 2'd3;
  logic [4:0] D_A3 = '0;
  logic       D_RegWrite = 1'b0;
  logic [1:0] D_Tnew = '0;
  logic       D_md_start = 1'b0;
  logic       D_md_div = 1'b0;
  logic       D_md_use = 1'b0;
  logic       stall;
  logic       E_md_start;
  logic       md_busy;
  logic [2:0] rsMUXop;
  logic [2:0] rtMUXop;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  d_hazard_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_A1      (D_A1),
    .D_A2      (D_A2),
    .D_rs_Tuse (D_rs_Tuse),
    .D_rt_Tuse (D_rt_Tuse),
    .D_A3      (D_A3),
    .D_RegWrite(D_RegWrite),
    .D_Tnew    (D_Tnew),
    .D_md_start(D_md_start),
    .D_md_div  (D_md_div),
    .D_md_use  (D_md_use),
    .stall     (stall),
    .E_md_start(E_md_start),
    .md_busy   (md_busy),
    .rsMUXop   (rsMUXop),
    .rtMUXop   (rtMUXop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic din_t ins(input int a1, input int a2, input int rsT,
                               input int rtT, input int a3, input int we,
                               input int tn);
    din_t d;
    d.a1  = 5'(a1);
    d.a2  = 5'(a2);
    d.rsT = 2'(rsT);
    d.rtT = 2'(rtT);
    d.a3  = 5'(a3);
    d.we  = 1'(we);
    d.tn  = 2'(tn);
    d.ms  = 1'b0;
    d.md  = 1'b0;
    d.mu  = 1'b0;
    return d;
  endfunction

  function automatic exp_t ex(input int st, input int rs, input int rt,
                              input int mds, input int bz);
    exp_t e;
    e.st  = 1'(st);
    e.rs  = 3'(rs);
    e.rt  = 3'(rt);
    e.mds = 1'(mds);
    e.bz  = 1'(bz);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs,
                     input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive D, queue expectation, check at negedge.
  task automatic step(input string tag, input din_t d, input exp_t e);
    exp_t x;
    D_A1       = d.a1;
    D_A2       = d.a2;
    D_rs_Tuse  = d.rsT;
    D_rt_Tuse  = d.rtT;
    D_A3       = d.a3;
    D_RegWrite = d.we;
    D_Tnew     = d.tn;
    D_md_start = d.ms;
    D_md_div   = d.md;
    D_md_use   = d.mu;
    q.push_back(e);
    @(negedge clk);
    x = q.pop_front();
    chk({tag, ".stall"}, {2'b0, stall}, {2'b0, x.st});
    chk({tag, ".rs"}, rsMUXop, x.rs);
    chk({tag, ".rt"}, rtMUXop, x.rt);
    chk({tag, ".mds"}, {2'b0, E_md_start}, {2'b0, x.mds});
    chk({tag, ".busy"}, {2'b0, md_busy}, {2'b0, x.bz});
    @(posedge clk);
    #1;
  endtask

  initial begin
    din_t nop;
    din_t d;
    nop = ins(0, 0, 3, 3, 0, 0, 0);

    reset = 1'b1;
    @(posedge clk);
    #1;
    step("rst", nop, ex(0, 0, 0, 0, 0));
    reset = 1'b0;
    step("rst2", nop, ex(0, 0, 0, 0, 0));

    // lw $1 then addu $2,$1,$3 (Tuse 1)
    step("lw1", ins(29, 0, 1, 3, 1, 1, 2), ex(0, 0, 0, 0, 0));
    step("addu_s", ins(1, 3, 1, 1, 2, 1, 1), ex(1, 0, 0, 0, 0));
    step("addu_go", ins(1, 3, 1, 1, 2, 1, 1), ex(0, 0, 0, 0, 0));
    step("or_w", ins(1, 0, 1, 1, 4, 1, 1), ex(0, 1, 0, 0, 0));
    step("nop1", nop, ex(0, 0, 0, 0, 0));

    // lw $6 then beq $6,$0 (Tuse 0)
    step("lw6", ins(29, 0, 1, 3, 6, 1, 2), ex(0, 0, 0, 0, 0));
    step("beq_s1", ins(6, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0));
    step("beq_s2", ins(6, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0));
    step("beq_go", ins(6, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0));

    // ori $5 then store of $5 (rt Tuse 2)
    step("ori5", ins(0, 0, 1, 3, 5, 1, 1), ex(0, 0, 0, 0, 0));
    step("sw_e", ins(29, 5, 1, 2, 0, 0, 0), ex(0, 0, 0, 0, 0));
    step("sw_m", ins(29, 5, 1, 2, 0, 0, 0), ex(0, 0, 2, 0, 0));
    step("sw_w", ins(29, 5, 1, 2, 0, 0, 0), ex(0, 0, 1, 0, 0));

    // jal then jr $31
    step("jal", ins(0, 0, 3, 3, 31, 1, 0), ex(0, 0, 0, 0, 0));
    step("jr", ins(31, 0, 0, 3, 0, 0, 0), ex(0, 3, 0, 0, 0));

    // two producers of $7: E beats M
    step("addu7", ins(0, 0, 1, 1, 7, 1, 1), ex(0, 0, 0, 0, 0));
    step("lui7", ins(0, 0, 3, 3, 7, 1, 0), ex(0, 0, 0, 0, 0));
    step("prio", ins(7, 7, 0, 0, 0, 0, 0), ex(0, 3, 3, 0, 0));

    // write to $0, then read $0
    step("w0", ins(0, 0, 1, 3, 0, 1, 1), ex(0, 0, 0, 0, 0));
    step("r0", ins(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0));

    // div then mflo: 11 stall cycles
    d = ins(8, 9, 1, 1, 0, 0, 0);
    d.ms = 1'b1;
    d.md = 1'b1;
    step("div", d, ex(0, 0, 0, 0, 0));
    d = ins(0, 0, 3, 3, 10, 1, 1);
    d.mu = 1'b1;
    step("mflo_s", d, ex(1, 0, 0, 1, 0));
    for (int i = 0; i < 10; i++) begin
      step("mflo_b", d, ex(1, 0, 0, 0, 1));
    end
    step("mflo_go", d, ex(0, 0, 0, 0, 0));

    // mult during a div window reloads with the mult latency
    d = ins(8, 9, 1, 1, 0, 0, 0);
    d.ms = 1'b1;
    d.md = 1'b1;
    step("div2", d, ex(0, 0, 0, 0, 0));
    step("div2_e", nop, ex(0, 0, 0, 1, 0));
    step("div2_b", nop, ex(0, 0, 0, 0, 1));
    d = ins(8, 9, 1, 1, 0, 0, 0);
    d.ms = 1'b1;
    step("mult", d, ex(0, 0, 0, 0, 1));
    step("mult_e", nop, ex(0, 0, 0, 1, 1));
    for (int i = 0; i < 5; i++) begin
      step("mult_b", nop, ex(0, 0, 0, 0, 1));
    end
    step("mult_end", nop, ex(0, 0, 0, 0, 0));

    // reset inside a div window
    d = ins(8, 9, 1, 1, 0, 0, 0);
    d.ms = 1'b1;
    d.md = 1'b1;
    step("div3", d, ex(0, 0, 0, 0, 0));
    step("div3_e", nop, ex(0, 0, 0, 1, 0));
    step("lui9", ins(0, 0, 3, 3, 9, 1, 0), ex(0, 0, 0, 0, 1));
    reset = 1'b1;
    step("rd9_rst", ins(9, 9, 0, 0, 0, 0, 0), ex(0, 3, 3, 0, 1));
    reset = 1'b0;
    step("rd9_clr", ins(9, 9, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0));
    d = ins(0, 0, 3, 3, 10, 1, 1);
    d.mu = 1'b1;
    step("mflo_clr", d, ex(0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
